// File: rtl/even_parity_pkg.sv
// Shared ALU definitions used by the parity generator and its neighbours
// in the 4-bit ALU datapath.
package even_parity_pkg;

   localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/even_parity_parity_reduce.sv
// Combinational XOR-reduction of a data word.
// p is 1 when data holds an odd number of ones.
module parity_reduce #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   output logic             p
);

   assign p = ^data;

endmodule

// File: rtl/even_parity.sv
// Registered even-parity generator for the two ALU operands.
// One parity bit per operand, captured on enable, held otherwise.
module even_parity
   import even_parity_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             E,
   output logic             ansA,
   output logic             ansB
);

   logic parA;
   logic parB;

   parity_reduce #(.WIDTH(WIDTH)) reduceA (
      .data (a),
      .p    (parA)
   );

   parity_reduce #(.WIDTH(WIDTH)) reduceB (
      .data (b),
      .p    (parB)
   );

   // Reset wins over enable; with E low the previous parity is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         ansA <= 1'b0;
         ansB <= 1'b0;
      end else if (E) begin
         ansA <= parA;
         ansB <= parB;
      end
   end

endmodule

// File: tb/tb_even_parity.sv
// Directed bench for even_parity: reset, capture, hold, full operand sweep,
// reset priority and back-to-back captures.
module tb_even_parity;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       E;
   logic       ansA;
   logic       ansB;

   int checkCount = 0;
   int errorCount = 0;

   logic [1:0] expQ[$];

   even_parity #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .E    (E),
      .ansA (ansA),
      .ansB (ansB)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst = 1'b1;
      E   = 1'b0;
      a   = '0;
      b   = '0;
   end

   function automatic logic popParity(input logic [3:0] x);
      int ones = 0;
      for (int i = 0; i < 4; i++) begin
         if (x[i]) ones++;
      end
      return (ones % 2 == 1);
   endfunction

   task automatic checkBits(input string tag, input logic [1:0] observed,
                            input logic [1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("FAIL %s: got {ansA,ansB}=%b expected %b", tag, observed, expected);
      end
   endtask

   // Driver: present one cycle of inputs, then compare the registered
   // outputs just after the edge against the queued expectation.
   task automatic applyCycle(input string tag, input logic r, input logic e,
                             input logic [3:0] va, input logic [3:0] vb,
                             input logic [1:0] expected);
      logic [1:0] want;
      rst = r;
      E   = e;
      a   = va;
      b   = vb;
      expQ.push_back(expected);
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      checkBits(tag, {ansA, ansB}, want);
   endtask

   initial begin
      #1;
      applyCycle("reset0", 1'b1, 1'b1, 4'd15, 4'd15, 2'b00);
      applyCycle("reset1", 1'b1, 1'b1, 4'd15, 4'd15, 2'b00);

      applyCycle("basic 12/13", 1'b0, 1'b1, 4'd12, 4'd13, 2'b01);

      for (int i = 0; i < 3; i++) begin
         applyCycle($sformatf("hold%0d", i), 1'b0, 1'b0, 4'd1, 4'd0, 2'b01);
      end
      applyCycle("after hold 1/0", 1'b0, 1'b1, 4'd1, 4'd0, 2'b10);

      for (int i = 0; i < 256; i++) begin
         logic [7:0] pair;
         pair = i[7:0];
         applyCycle($sformatf("sweep a=%0d b=%0d", pair[7:4], pair[3:0]),
                    1'b0, 1'b1, pair[7:4], pair[3:0],
                    {popParity(pair[7:4]), popParity(pair[3:0])});
      end

      applyCycle("rst priority", 1'b1, 1'b1, 4'd7, 4'd8, 2'b00);
      applyCycle("resume 7/8", 1'b0, 1'b1, 4'd7, 4'd8, 2'b11);

      applyCycle("b2b a=1", 1'b0, 1'b1, 4'd1, 4'd0, 2'b10);
      applyCycle("b2b a=3", 1'b0, 1'b1, 4'd3, 4'd0, 2'b00);
      applyCycle("b2b a=7", 1'b0, 1'b1, 4'd7, 4'd0, 2'b10);
      applyCycle("b2b a=15", 1'b0, 1'b1, 4'd15, 4'd0, 2'b00);

      applyCycle("hold after b2b", 1'b0, 1'b0, 4'd1, 4'd1, 2'b00);

      // Final report
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/even_parity.md
Name: even_parity

Overview:
- Registered even-parity generator for the two 4-bit ALU operands, a and b.
- When enabled, it computes the parity bit for each operand that makes the operand plus that bit contain an even number of ones.
- Sits beside the 4-bit ALU datapath and supplies its parity-function outputs.
- One clock domain; outputs are registered with 1-cycle latency.

Parameters:
- WIDTH, 4, operand width in bits; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- E  input  1  enable; 1 = capture new parity, 0 = hold outputs.
- ansA  output  1  registered even-parity bit of a.
- ansB  output  1  registered even-parity bit of b.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: when rst=1 at a rising clk edge, ansA and ansB become 0.
  - rst has priority over E.
  - Both outputs also read 0 from the first reset edge until the first enabled capture.
- Parity rule: parity(x) is the XOR-reduction of all WIDTH bits of x.
  - Result is 1 when x has an odd number of ones, else 0.
  - Hence x concatenated with parity(x) always has an even number of ones.
- Capture: when rst=0 and E=1 at a rising edge, ansA <= parity(a) and ansB <= parity(b).
  - Latency: exactly 1 clock from input sample to output.
- Hold: when rst=0 and E=0, ansA and ansB keep their previous values.
  - Changes on a and b are ignored while E=0.
- No combinational path from any input to any output; outputs change only on clk edges.
- No handshake and no back-pressure; a new capture can occur every cycle.
- X-handling: inputs must be known whenever E=1. Behaviour with unknown inputs while E=1 is unspecified.
- Boundary values:
  - a=0 gives ansA=0.
  - All-ones on a gives ansA = WIDTH mod 2 (0 for WIDTH=4).
  - The same rules apply to b and ansB.
- Reset asserted mid-stream: the outputs on the next edge are 0. Capture resumes on the first edge with rst=0 and E=1.

Decomposition:
- Shared ALU package: the default operand width constant (4), used for WIDTH.
- Sub-module parity_reduce:
  - Parameter WIDTH; input data [WIDTH-1:0]; output p = XOR-reduction of data.
  - Purely combinational.
  - Instantiated twice, once for a and once for b.
- Top level even_parity: the two output registers, plus reset, enable and hold logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=15, b=15, E=1 -> ansA=0 and ansB=0 throughout.
- Basic capture: rst=0, a=12 (1100), b=13 (1101), E=1 -> one edge later ansA=0, ansB=1.
- Hold: after the basic capture, set E=0 and change to a=1, b=0 for 3 cycles -> ansA=0 and ansB=1 unchanged. Then set E=1 -> next edge ansA=1, ansB=0.
- Exhaustive sweep: with E=1, run all 256 (a,b) pairs, one per cycle -> each output equals the popcount mod 2 of its operand, delayed 1 cycle. Includes a=0 gives 0 and a=15 gives 0.
- Reset priority: with E=1, a=7, b=8, assert rst=1 for one cycle -> outputs 0 on that edge. The next edge with rst=0 and a=7, b=8 gives ansA=1, ansB=1.
- Back-to-back captures: a=1,3,7,15 on consecutive cycles with E=1 -> ansA sequence 1,0,1,0, each value one cycle after its input.
